// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable bit period, width, parity and stop bits.
// Reports parity/framing/break/overrun alongside a valid/ready output register.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) >> 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic                 meta, rx;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc;
  logic                 frm_err;
  logic                 seen_one;

  logic at_last, counting, sampling, done, parity_err_now;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b1;
      rx   <= 1'b1;
    end else begin
      meta <= i_rxd;
      rx   <= meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  assign at_last = (cnt == LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!rx) state_next = S_START;
      S_START:     if (cnt == HALF) state_next = rx ? S_IDLE : S_DATA;
      S_DATA:      if (at_last && idx == LAST_IDX)
                     state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (at_last) state_next = S_STOP;
      S_STOP:      if (at_last && stop_idx == LAST_STOP) state_next = S_DONE;
      S_DONE:      state_next = frm_err ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (rx) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state != S_IDLE);
    done     = (state == S_DONE);
    counting = (state == S_START) || (state == S_DATA) ||
               (state == S_PARITY) || (state == S_STOP);
    sampling = at_last && ((state == S_DATA) || (state == S_PARITY) || (state == S_STOP));
    if (PARITY == 1)      parity_err_now = ~par_acc;
    else if (PARITY == 2) parity_err_now = par_acc;
    else                  parity_err_now = 1'b0;
  end

  // Counter restarts on every state change and after every bit-centre sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_acc  <= 1'b0;
      frm_err  <= 1'b0;
      seen_one <= 1'b0;
    end else begin
      if (!counting || state_next != state || sampling) cnt <= '0;
      else                                             cnt <= cnt + CW'(1);

      if (state == S_IDLE) begin
        idx      <= '0;
        stop_idx <= 1'b0;
        par_acc  <= 1'b0;
        frm_err  <= 1'b0;
        seen_one <= 1'b0;
      end else if (sampling) begin
        seen_one <= seen_one | rx;
        case (state)
          S_DATA: begin
            shift   <= {rx, shift[DATA_BITS-1:1]};
            idx     <= idx + IW'(1);
            par_acc <= par_acc ^ rx;
          end
          S_PARITY: par_acc <= par_acc ^ rx;
          S_STOP: begin
            if (!rx) frm_err <= 1'b1;
            stop_idx <= ~stop_idx;
          end
          default: ;
        endcase
      end
    end
  end

  // A word finishing on a transfer cycle replaces the outgoing one without a gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (done && (!o_valid || i_ready)) begin
        o_valid      <= 1'b1;
        o_data       <= shift;
        o_parity_err <= parity_err_now;
        o_frame_err  <= frm_err;
        o_break      <= ~seen_one;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (done && o_valid && !i_ready) o_overrun <= 1'b1;
      else if (o_valid && i_ready)     o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 9-bit even-parity two-stop instance,
// directed frames plus random frames scored against a word-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) >> 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd_a, rxd_b, rdy_a, rdy_b;
  logic       va, pea, fea, ba, oa, bsa;
  logic [7:0] da;
  logic       vb, peb, feb, bb, ob, bsb;
  logic [8:0] db;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd_a), .i_ready(rdy_a),
    .o_valid(va), .o_data(da), .o_parity_err(pea), .o_frame_err(fea),
    .o_break(ba), .o_overrun(oa), .o_busy(bsa)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd_b), .i_ready(rdy_b),
    .o_valid(vb), .o_data(db), .o_parity_err(peb), .o_frame_err(feb),
    .o_break(bb), .o_overrun(ob), .o_busy(bsb)
  );

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } word_t;

  word_t q_a[$];
  word_t q_b[$];
  word_t wa, wb;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Every accepted word must match the oldest expected word of its instance.
  always @(negedge clk) begin
    if (va && rdy_a) begin
      if (q_a.size() == 0) check("a_spurious_valid", 32'(1), 32'(0));
      else begin
        wa = q_a.pop_front();
        check("a_data", 32'(da), 32'(wa.data[7:0]));
        check("a_parity_err", 32'(pea), 32'(wa.perr));
        check("a_frame_err", 32'(fea), 32'(wa.ferr));
        check("a_break", 32'(ba), 32'(wa.brk));
      end
    end
    if (vb && rdy_b) begin
      if (q_b.size() == 0) check("b_spurious_valid", 32'(1), 32'(0));
      else begin
        wb = q_b.pop_front();
        check("b_data", 32'(db), 32'(wb.data));
        check("b_parity_err", 32'(peb), 32'(wb.perr));
        check("b_frame_err", 32'(feb), 32'(wb.ferr));
        check("b_break", 32'(bb), 32'(wb.brk));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic hold(input int which, input logic v, input int ncyc);
    if (which == 0) rxd_a = v;
    else            rxd_b = v;
    tick(ncyc);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop, input bit expect_it);
    word_t w;
    if (expect_it) begin
      w.data = {1'b0, d};
      w.perr = 1'b0;
      w.ferr = !stop;
      w.brk  = (d == 8'h00) && !stop;
      q_a.push_back(w);
    end
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(0, d[i], CPB);
    hold(0, stop, CPB);
    rxd_a = 1'b1;
  endtask

  task automatic frame_b(input logic [8:0] d, input logic p, input logic [1:0] stops,
                         input bit expect_it);
    word_t w;
    if (expect_it) begin
      w.data = d;
      w.perr = ^{d, p};
      w.ferr = !(stops[0] && stops[1]);
      w.brk  = (d == 9'h000) && !p && (stops == 2'b00);
      q_b.push_back(w);
    end
    hold(1, 1'b0, CPB);
    for (int i = 0; i < 9; i++) hold(1, d[i], CPB);
    hold(1, p, CPB);
    hold(1, stops[0], CPB);
    hold(1, stops[1], CPB);
    rxd_b = 1'b1;
  endtask

  initial begin
    logic [8:0] d9;
    logic [7:0] d8;
    logic       p;
    logic [1:0] st;
    int         k;

    rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    tick(3);
    check("rst_a_valid", 32'(va), 32'(0));
    check("rst_a_data", 32'(da), 32'(0));
    check("rst_a_flags", 32'({pea, fea, ba, oa}), 32'(0));
    check("rst_a_busy", 32'(bsa), 32'(0));
    check("rst_b_valid", 32'(vb), 32'(0));
    check("rst_b_data", 32'(db), 32'(0));
    check("rst_b_flags", 32'({peb, feb, bb, ob}), 32'(0));
    check("rst_b_busy", 32'(bsb), 32'(0));
    rst = 1'b0;
    tick(2 * CPB);

    // Clean 8N1 word
    frame_a(8'hA5, 1'b1, 1'b1);
    hold(0, 1'b1, 2 * CPB);

    // Even parity: wrong then right parity bit
    frame_b(9'h003, 1'b1, 2'b11, 1'b1);
    hold(1, 1'b1, 2 * CPB);
    frame_b(9'h003, 1'b0, 2'b11, 1'b1);
    hold(1, 1'b1, 2 * CPB);

    // Framing error, then a held-low break, then recovery
    frame_a(8'h55, 1'b0, 1'b1);
    hold(0, 1'b1, 2 * CPB);
    wa = '{data: 9'h000, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
    q_a.push_back(wa);
    hold(0, 1'b0, 12 * CPB);
    hold(0, 1'b1, 2 * CPB);
    frame_a(8'h5A, 1'b1, 1'b1);
    hold(0, 1'b1, 2 * CPB);
    check("a_pending_break", 32'(q_a.size()), 32'(0));

    // Overrun: second word dropped while the first is held
    rdy_a = 1'b0;
    frame_a(8'h11, 1'b1, 1'b1);
    frame_a(8'h22, 1'b1, 1'b0);
    hold(0, 1'b1, 2 * CPB);
    check("ovr_valid_held", 32'(va), 32'(1));
    check("ovr_data_held", 32'(da), 32'(8'h11));
    check("ovr_flag_set", 32'(oa), 32'(1));
    rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    check("ovr_valid_drop", 32'(va), 32'(0));
    check("ovr_flag_clear", 32'(oa), 32'(0));
    rdy_a = 1'b1;
    tick(CPB);

    // Short glitch is rejected
    hold(0, 1'b0, 4);
    rxd_a = 1'b1;
    check("glitch_busy_rose", 32'(bsa), 32'(1));
    k = 0;
    while (bsa && k < HALF + 3) begin
      tick(1);
      k++;
    end
    check("glitch_busy_fell", 32'(bsa), 32'(0));
    hold(0, 1'b1, 2 * CPB);
    check("a_pending_glitch", 32'(q_a.size()), 32'(0));

    // Back-to-back 9-bit frames
    frame_b(9'h1FF, ^9'h1FF, 2'b11, 1'b1);
    frame_b(9'h001, ^9'h001, 2'b11, 1'b1);
    hold(1, 1'b1, 2 * CPB);
    check("b_pending_b2b", 32'(q_b.size()), 32'(0));

    // Reset during data bit 3 of an abandoned frame
    d9 = 9'h0F5;
    hold(1, 1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(1, d9[i], CPB);
    rxd_b = d9[3];
    tick(CPB / 2);
    check("midframe_busy", 32'(bsb), 32'(1));
    rst = 1'b1;
    rxd_b = 1'b1;
    tick(2);
    check("midrst_b_valid", 32'(vb), 32'(0));
    check("midrst_b_busy", 32'(bsb), 32'(0));
    check("midrst_b_data", 32'(db), 32'(0));
    check("midrst_a_valid", 32'(va), 32'(0));
    rst = 1'b0;
    tick(3 * CPB);
    frame_b(9'h03C, ^9'h03C, 2'b11, 1'b1);
    hold(1, 1'b1, 2 * CPB);

    // Random frames with occasional parity/stop faults and all-zero data
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        d8 = 8'($urandom);
        if ($urandom_range(0, 7) == 0) d8 = 8'h00;
        frame_a(d8, ($urandom_range(0, 5) != 0), 1'b1);
        hold(0, 1'b1, $urandom_range(1, 3) * CPB);
      end else begin
        d9 = 9'($urandom);
        if ($urandom_range(0, 7) == 0) d9 = 9'h000;
        p  = (^d9) ^ ($urandom_range(0, 3) == 0);
        st = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
        frame_b(d9, p, st, 1'b1);
        hold(1, 1'b1, $urandom_range(1, 3) * CPB);
      end
    end

    tick(2 * CPB);
    check("a_pending_end", 32'(q_a.size()), 32'(0));
    check("b_pending_end", 32'(q_b.size()), 32'(0));
    check("a_overrun_end", 32'(oa), 32'(0));
    check("b_overrun_end", 32'(ob), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
